pmem_arbiter: RTL and testbench
===============================

// Module: pmem_arbiter
// PURPOSE
//  Shares the single physical-memory port between the instruction cache (I) and data cache (D)
//  of the pipelined RV32I core. Requests are cacheline-sized. One request is granted at a time;
//  the request's address/wdata are held stable on pmem until pmem_resp, which is routed back
//  only to the granted requester. Sits between the L1 caches and the cacheline adaptor.
// PARAMETERS
//  LINE_W   256  cacheline width in bits (pmem/I/D data buses)
//  ADDR_W   32   byte address width; line-aligned, low log2(LINE_W/8) bits are forced to 0
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       synchronous, active-high reset
//  i_read       in   1       I-cache line read request; held high until i_resp
//  i_address    in   ADDR_W  I-cache request address
//  i_rdata      out  LINE_W  line returned to I-cache (valid when i_resp)
//  i_resp       out  1       1-cycle completion pulse to I-cache
//  d_read       in   1       D-cache line read request; held until d_resp
//  d_write      in   1       D-cache line writeback request; held until d_resp
//  d_address    in   ADDR_W  D-cache request address
//  d_wdata      in   LINE_W  D-cache writeback line
//  d_rdata      out  LINE_W  line returned to D-cache (valid when d_resp)
//  d_resp       out  1       1-cycle completion pulse to D-cache
//  pmem_read    out  1       read request to memory
//  pmem_write   out  1       write request to memory
//  pmem_address out  ADDR_W  latched, line-aligned address
//  pmem_wdata   out  LINE_W  latched write line
//  pmem_rdata   in   LINE_W  line from memory
//  pmem_resp    in   1       memory completion pulse
// BEHAVIOUR
//  - FSM states: IDLE, GRANT_I, GRANT_D, DONE. Reset -> IDLE; all outputs 0, latches cleared.
//  - IDLE: if any request is pending, pick a winner, latch its address (low bits zeroed),
//    wdata and op (rd/wr) into registers, and go to GRANT_I/GRANT_D next cycle.
//  - Default arbitration: fixed priority D over I, because the D access belongs to the older
//    instruction.
//  - GRANT_x: pmem_read/pmem_write driven from the latched op; address/wdata from latches,
//    stable for the entire grant.
//  - pmem_resp in GRANT_x: x_resp=1 in the same cycle, x_rdata=pmem_rdata (combinational
//    pass). Next state is DONE.
//  - DONE: one cycle; pmem_read/write=0. The requester deasserts here. Then go to IDLE.
//  - Latency: request seen at cycle t -> pmem request at t+1 -> resp at k -> next grant
//    earliest at k+3.
//  - The non-granted x_resp is always 0. The non-granted x_rdata is 0.
//  - pmem_resp in IDLE or DONE is ignored: no resp, no state change.
//  - d_read & d_write both high: write wins. This is illegal; a simulation-only assertion fires.
//  - A request arriving during another grant waits. Requests are never dropped; this is
//    guaranteed by the level-held protocol.
//  - rst mid-grant: the next cycle is IDLE and pmem_read/write=0. The in-flight memory op is
//    abandoned, and pmem must accept abandonment.
//  - Request inputs change while granted: ignored, because the latches are authoritative.
// CONFIGURATION
//  PMEM_ARB_RR_EN defined: round-robin. When both I and D pend in IDLE, grant the requester
//    NOT served last. The last_grant flop resets to I, so D wins the first tie.
//    A single pending requester is always granted.
//  PMEM_ARB_RR_EN undefined: fixed D>I priority. No last_grant flop exists.
// TESTING
//  1. i_read=1, addr 0x0000_1234; pmem_resp 5 cycles later, rdata=0xA5.. ->
//     pmem_address=0x0000_1220; i_resp pulses once with i_rdata=0xA5..; d_resp stays 0.
//  2. d_write=1, addr 0x80, wdata=0xDEAD.. -> pmem_write=1, pmem_wdata=0xDEAD..,
//     pmem_read=0 until pmem_resp; d_resp=1 that cycle.
//  3. i_read and d_read high in the same cycle, with three consecutive tie rounds ->
//     fixed: D,D,D. With PMEM_ARB_RR_EN: D,I,D.
//  4. Assert rst 2 cycles into GRANT_D -> next cycle state IDLE and pmem_read=0. A later
//     pmem_resp produces no d_resp.
//  5. pmem_resp pulsed while IDLE -> no i_resp/d_resp, no pmem request, state unchanged.
//  6. Change i_address to 0x40 mid-grant (original 0x100) -> pmem_address stays 0x100
//     until DONE.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Arbitrates one cacheline-sized physical-memory port between I-cache and D-cache; pmem request 1 cycle after pickup, resp routed same cycle, DONE+IDLE before next grant.
// Requests are level-held until x_resp, so losers simply wait; PMEM_ARB_RR_EN selects round-robin instead of fixed D>I priority.
module pmem_arbiter #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int OFFSET_W = $clog2(LINE_W / 8);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic              read_q, write_q, wr_d;
   logic              d_pend, pick_d;

   assign d_pend = d_read | d_write;

`ifdef PMEM_ARB_RR_EN
   // last_d_q=0 means I was served last, so D wins the first tie after reset
   logic last_d_q;
   assign pick_d = d_pend & (~i_read | ~last_d_q);
`else
   assign pick_d = d_pend;
`endif

   always_comb begin
      addr_d  = (pick_d ? d_address : i_address) & ADDR_MASK;
      wdata_d = pick_d ? d_wdata : '0;
      wr_d    = pick_d & d_write;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
`ifdef PMEM_ARB_RR_EN
         last_d_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (d_pend | i_read) begin
                  addr_q   <= addr_d;
                  wdata_q  <= wdata_d;
                  read_q   <= ~wr_d;
                  write_q  <= wr_d;
                  state_q  <= pick_d ? GRANT_D : GRANT_I;
`ifdef PMEM_ARB_RR_EN
                  last_d_q <= pick_d;
`endif
               end
            end
            GRANT_I, GRANT_D: begin
               if (pmem_resp) begin
                  state_q <= DONE;
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pmem_read    = read_q;
   assign pmem_write   = write_q;
   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;

   // Memory data passes straight through to whichever side holds the grant
   assign i_resp  = (state_q == GRANT_I) & pmem_resp;
   assign d_resp  = (state_q == GRANT_D) & pmem_resp;
   assign i_rdata = (state_q == GRANT_I) ? pmem_rdata : '0;
   assign d_rdata = (state_q == GRANT_D) ? pmem_rdata : '0;

`ifndef SYNTHESIS
   a_no_rd_wr: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: reset, I read, D writeback, tie arbitration, reset abandonment, stray resp, address latching.
module tb_pmem_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_read, d_read, d_write, pmem_resp;
   logic [31:0]  i_address, d_address;
   logic [255:0] d_wdata, pmem_rdata;
   logic [255:0] i_rdata, d_rdata, pmem_wdata;
   logic         i_resp, d_resp, pmem_read, pmem_write;
   logic [31:0]  pmem_address;

   int tests = 0;
   int fails = 0;

   pmem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      while (!(pmem_read || pmem_write) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_grant_timeout"}, 256'(pmem_read || pmem_write), 256'(1));
   endtask

   // Pulses pmem_resp for one cycle; returns at the negedge of the DONE cycle
   task automatic respond(input logic [255:0] rd, output logic ir, output logic dr,
                          output logic [255:0] ird, output logic [255:0] drd);
      pmem_resp  = 1'b1;
      pmem_rdata = rd;
      #1;
      ir = i_resp; dr = d_resp; ird = i_rdata; drd = d_rdata;
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
   endtask

   logic         ir, dr;
   logic [255:0] ird, drd;
   logic [255:0] line_a5, line_dead, line_x;
   logic         exp_d [3];

   initial begin
      line_a5   = {32{8'hA5}};
      line_dead = {8{32'hDEADBEEF}};
      rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
      i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_pmem_read", 256'(pmem_read), 256'(0));
      chk("rst_pmem_write", 256'(pmem_write), 256'(0));
      chk("rst_pmem_address", 256'(pmem_address), 256'(0));
      chk("rst_resps", 256'({i_resp, d_resp}), 256'(0));
      rst = 1'b0;
      @(negedge clk);

      // 1: I read, line-aligned address, resp 5 cycles after the request
      i_read = 1'b1; i_address = 32'h0000_1234;
      @(negedge clk);
      chk("t1_pmem_read", 256'(pmem_read), 256'(1));
      chk("t1_pmem_write", 256'(pmem_write), 256'(0));
      chk("t1_addr", 256'(pmem_address), 256'(32'h0000_1220));
      repeat (4) @(negedge clk);
      chk("t1_no_early_resp", 256'(i_resp), 256'(0));
      respond(line_a5, ir, dr, ird, drd);
      chk("t1_i_resp", 256'(ir), 256'(1));
      chk("t1_i_rdata", ird, line_a5);
      chk("t1_d_resp", 256'(dr), 256'(0));
      chk("t1_d_rdata", drd, 256'(0));
      i_read = 1'b0;
      #1;
      chk("t1_done_resp", 256'(i_resp), 256'(0));
      chk("t1_done_read", 256'(pmem_read), 256'(0));
      @(negedge clk);

      // 2: D writeback
      d_write = 1'b1; d_address = 32'h80; d_wdata = line_dead;
      @(negedge clk);
      chk("t2_pmem_write", 256'(pmem_write), 256'(1));
      chk("t2_pmem_wdata", pmem_wdata, line_dead);
      chk("t2_addr", 256'(pmem_address), 256'(32'h80));
      @(negedge clk);
      chk("t2_pmem_read", 256'(pmem_read), 256'(0));
      respond(256'(0), ir, dr, ird, drd);
      chk("t2_d_resp", 256'(dr), 256'(1));
      chk("t2_i_resp", 256'(ir), 256'(0));
      d_write = 1'b0; d_wdata = '0;
      @(negedge clk);

      // 3: three tie rounds; the winner drops its request in DONE and re-raises it in IDLE
`ifdef PMEM_ARB_RR_EN
      exp_d[0] = 1'b1; exp_d[1] = 1'b0; exp_d[2] = 1'b1;
`else
      exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1;
`endif
      i_address = 32'h1000; d_address = 32'h2000;
      i_read = 1'b1; d_read = 1'b1;
      for (int r = 0; r < 3; r++) begin
         wait_grant("t3");
         chk($sformatf("t3_r%0d_addr", r), 256'(pmem_address),
             256'(exp_d[r] ? 32'h2000 : 32'h1000));
         line_x = {8{r[31:0] + 32'h5A5A_0000}};
         respond(line_x, ir, dr, ird, drd);
         chk($sformatf("t3_r%0d_route", r), 256'({dr, ir}), 256'({exp_d[r], ~exp_d[r]}));
         chk($sformatf("t3_r%0d_rdata", r), exp_d[r] ? drd : ird, line_x);
         if (exp_d[r]) d_read = 1'b0; else i_read = 1'b0;
         @(negedge clk);
         d_read = 1'b1; i_read = 1'b1;
      end
      d_read = 1'b0;
      // drain the remaining I request (it was never dropped)
      wait_grant("t3_drain");
      chk("t3_drain_addr", 256'(pmem_address), 256'(32'h1000));
      respond(256'(0), ir, dr, ird, drd);
      chk("t3_drain_i_resp", 256'(ir), 256'(1));
      i_read = 1'b0;
      @(negedge clk);

      // 4: reset two cycles into GRANT_D abandons the op
      d_read = 1'b1; d_address = 32'h300;
      @(negedge clk);
      chk("t4_granted", 256'(pmem_read), 256'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t4_rst_read", 256'(pmem_read), 256'(0));
      chk("t4_rst_addr", 256'(pmem_address), 256'(0));
      rst = 1'b0; d_read = 1'b0;
      @(negedge clk);
      respond(line_a5, ir, dr, ird, drd);
      chk("t4_late_d_resp", 256'(dr), 256'(0));
      chk("t4_late_d_rdata", drd, 256'(0));
      chk("t4_late_pmem_read", 256'(pmem_read), 256'(0));

      // 5: stray pmem_resp in IDLE is ignored
      @(negedge clk);
      respond(line_a5, ir, dr, ird, drd);
      chk("t5_resps", 256'({ir, dr}), 256'(0));
      chk("t5_no_req", 256'({pmem_read, pmem_write}), 256'(0));
      i_read = 1'b1; i_address = 32'h100;
      @(negedge clk);
      chk("t5_still_idle", 256'(pmem_read), 256'(1));

      // 6: request inputs change mid-grant; latched address holds through DONE
      i_address = 32'h40;
      @(negedge clk);
      chk("t6_addr_hold1", 256'(pmem_address), 256'(32'h100));
      @(negedge clk);
      chk("t6_addr_hold2", 256'(pmem_address), 256'(32'h100));
      respond(line_a5, ir, dr, ird, drd);
      chk("t6_i_resp", 256'(ir), 256'(1));
      chk("t6_addr_done", 256'(pmem_address), 256'(32'h100));
      i_read = 1'b0;
      @(negedge clk);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
